tree_feed_ctrl: RTL
===================

TREE_FEED_CTRL -- requirements
Module: tree_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the word width on all data ports.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the input buffer entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter TREE_LAT, default 5, the register-tree latency in cycles, at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 SHALL have port in_data, input, DATA_WIDTH bits: the upstream word.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 SHALL have port pause, input, 1 bit: consumers request bubbles and no issue.
REQ-010 SHALL have port flush, input, 1 bit: discard all buffered and in-flight valid words.
REQ-011 SHALL have port tree_in, output, DATA_WIDTH bits: drives the fan-out tree input.
REQ-012 SHALL have port tree_valid, output, 1 bit: tree_in holds an issued word this cycle.
REQ-013 SHALL have port out_valid, output, 1 bit: tree_valid delayed by TREE_LAT cycles, aligned with the tree outputs.
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-015 SHALL have port issued_cnt, output, 16 bits: the count of issued words, wrapping modulo 2^16.

Function
REQ-016 SHALL accept a word on every rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL assert in_ready only when FIFO occupancy < FIFO_DEPTH and flush=0.
REQ-018 SHALL NOT let a same-cycle pop raise in_ready; there is no full-FIFO pass-through.
REQ-019 SHALL issue the FIFO head on each edge where the FIFO is non-empty, pause=0 and flush=0: the head word is registered onto tree_in, tree_valid=1 the following cycle, and the entry is popped.
REQ-020 SHALL give an empty-FIFO word a minimum latency of 1 cycle from acceptance edge to tree_valid.
REQ-021 SHALL give a minimum latency of 1+TREE_LAT cycles from acceptance edge to out_valid.
REQ-022 SHALL register tree_valid=0 on any non-issue edge.
REQ-023 SHALL, on bubble cycles, drive tree_in per REQ-034/REQ-035.
REQ-024 SHALL allow push and pop on the same edge, leaving occupancy unchanged and preserving FIFO order.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, with occupancy held in a separate log2(FIFO_DEPTH)+1-bit count.
REQ-026 SHALL implement out_valid as a TREE_LAT-stage shift of tree_valid.
REQ-027 SHALL, when flush=1 on an edge:
- empty the FIFO;
- zero the tree_valid register and every stage of the valid shift;
- push nothing (flush has priority over push and issue);
- leave issued_cnt unchanged.
REQ-028 SHALL increment issued_cnt by 1 on each issue edge, wrapping from 0xFFFF to 0x0000.
REQ-029 SHALL implement a three-state FSM IDLE, RUN, DRAIN with these transitions:
- IDLE->RUN when a word is accepted;
- RUN->DRAIN when the FIFO becomes empty with valid still in flight;
- DRAIN->RUN on acceptance;
- DRAIN->IDLE when tree_valid and all shift stages are 0;
- any state->IDLE on flush.
REQ-030 SHALL NOT change FSM state on pause alone.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: FIFO empty, pointers 0, tree_in=0, tree_valid=0, valid shift all 0, out_valid=0, issued_cnt=0, FSM=IDLE, busy=0.
REQ-032 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-033 SHALL, on reset mid-operation, discard all words and not issue them later.

Configuration
REQ-034 SHALL, with TREE_FEED_BUBBLE_ZERO_EN defined, register tree_in to 0 on every non-issue edge.
REQ-035 SHALL, without TREE_FEED_BUBBLE_ZERO_EN, hold the last issued word on tree_in during bubbles, which saves toggle power; valid signalling is identical in both builds.

Structure
REQ-036 SHALL place the FSM state encoding (IDLE=0, RUN=1, DRAIN=2, 2 bits) and the issued_cnt width constant in shared package tree_feed_pkg.
REQ-037 SHALL place the FIFO storage, pointers and occupancy in one sub-module, tree_feed_fifo.
REQ-038 SHALL keep the FSM, issue logic, valid shift and counter in the top module.

Verification
REQ-039 SHALL cover single word: push 0x00A5 at edge 0 into an idle block -> tree_in=0x00A5 with tree_valid=1 in cycle 1; out_valid=1 in cycle 6 only (TREE_LAT=5); busy returns to 0 in cycle 7.
REQ-040 SHALL cover back-to-back full: push 6 words with pause=1 -> in_ready falls after the 4th; releasing pause issues 4 words on consecutive cycles in order; issued_cnt=4.
REQ-041 SHALL cover simultaneous push and pop: with occupancy 2, push and issue on the same edge -> occupancy stays 2; the output order matches input order.
REQ-042 SHALL cover flush mid-stream: flush with 3 buffered words and 2 in flight -> no further tree_valid or out_valid pulses; FSM=IDLE next cycle; issued_cnt unchanged.
REQ-043 SHALL cover counter wrap and bubble value: preset traffic to 0xFFFF issues, one more issue gives issued_cnt=0x0000; a bubble gives tree_in=0 with the macro defined and last word held without it.
REQ-044 SHALL cover async reset: assert rst_n=0 mid-cycle during RUN -> all outputs 0 immediately; no stale word appears after release.

Source files
------------

// File: rtl/tree_feed_pkg.sv
// Shared constants for the tree feed controller: FSM encoding and counter width.
package tree_feed_pkg;

  localparam int unsigned CNT_W = 16;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_RUN   = 2'd1;
  localparam fsm_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/tree_feed_fifo.sv
// Input buffer for tree_feed_ctrl: power-of-2 circular FIFO with a separate occupancy count.
// Callers gate push with !full and pop with !empty; flush empties the buffer and wins over both.
module tree_feed_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PTR_W:0]        count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

endmodule

// File: rtl/tree_feed_ctrl.sv
// Feeds a fan-out register tree from a small input FIFO; tracks tree latency with a valid shift.
// Optional macro TREE_FEED_BUBBLE_ZERO_EN: zero tree_in on bubbles instead of holding the last word.
module tree_feed_ctrl
  import tree_feed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TREE_LAT   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  pause,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] tree_in,
  output logic                  tree_valid,
  output logic                  out_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      issued_cnt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_nxt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  issue;
  logic [TREE_LAT-1:0]   vshift;
  logic [TREE_LAT-1:0]   vshift_nxt;
  fsm_state_t            state;
  fsm_state_t            state_nxt;

  assign in_ready  = !fifo_full && !flush;
  assign accept    = in_valid && in_ready;
  assign issue     = !fifo_empty && !pause && !flush;
  assign count_nxt = fifo_count + CW'(accept) - CW'(issue);
  assign out_valid = vshift[TREE_LAT-1];
  assign busy      = (state != ST_IDLE);

  tree_feed_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (accept),
    .pop     (issue),
    .wr_data (in_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  generate
    if (TREE_LAT == 1) begin : g_shift1
      assign vshift_nxt = flush ? 1'b0 : tree_valid;
    end else begin : g_shiftn
      assign vshift_nxt = flush ? '0 : {vshift[TREE_LAT-2:0], tree_valid};
    end
  endgenerate

  // DRAIN exit looks at next-cycle valids so busy drops the cycle after out_valid's last pulse.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nxt = ST_RUN;
        ST_RUN:   if (count_nxt == '0) state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (accept)
            state_nxt = ST_RUN;
          else if (!issue && (vshift_nxt == '0))
            state_nxt = ST_IDLE;
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tree_in    <= '0;
      tree_valid <= 1'b0;
      vshift     <= '0;
      issued_cnt <= '0;
    end else begin
      state      <= state_nxt;
      tree_valid <= issue;
      vshift     <= vshift_nxt;
      if (issue) begin
        tree_in    <= fifo_head;
        issued_cnt <= issued_cnt + 1'b1;
      end
`ifdef TREE_FEED_BUBBLE_ZERO_EN
      else begin
        tree_in <= '0;
      end
`endif
    end
  end

endmodule
